alarm_pulse_decoder: RTL and testbench
======================================

// Module: alarm_pulse_decoder
// PURPOSE
//  Reader side of the sensor/buzzer alarm path. Monitors the three one-hot buzzer lines from the alarm
//  state machine and checks that each alarm is a single-zone pulse of nominal length. Reports each valid
//  alarm as a zone code on a valid/ack handshake, keeps saturating per-zone event counts, and flags
//  malformed pulses. Sits downstream of the alarm FSM, same clock domain.
// PARAMETERS
//  PULSE_LEN  31  nominal buzzer high time, in clk cycles
//  TOL        1   accepted deviation, in cycles: valid if PULSE_LEN-TOL <= len <= PULSE_LEN+TOL
//  LEN_W      6   pulse-length counter width; saturates at 2^LEN_W-1
//  CNT_W      8   per-zone event counter width; saturates at 2^CNT_W-1
// PORTS
//  clk          in   1      clock; all logic on posedge
//  rst_n        in   1      asynchronous active-low reset
//  buzzer_in    in   3      buzzer lines, bit0=zone1 .. bit2=zone3
//  evt_ack      in   1      consumer accepts the pending event
//  clr_counts   in   1      synchronous clear of all zone counters
//  evt_valid    out  1      event pending; held until acked
//  evt_zone     out  2      zone of pending event (1..3); 0 when evt_valid=0
//  len_err      out  1      1-cycle pulse: single-zone pulse outside tolerance
//  multi_err    out  1      1-cycle pulse: more than one buzzer line high
//  overrun      out  1      sticky: valid event lost because previous one unacked; cleared by reset only
//  zone1_cnt    out  CNT_W  accepted events, zone 1
//  zone2_cnt    out  CNT_W  accepted events, zone 2
//  zone3_cnt    out  CNT_W  accepted events, zone 3
// BEHAVIOUR
//  Reset: every output is 0; FSM=IDLE; length counter=0; input register b_q=0.
//  b_q <= buzzer_in every cycle. The FSM acts on b_q only (one cycle of input latency).
//  States and transitions:
//  - IDLE: b_q==0 -> stay. b_q one-hot -> latch zone, len=1, MEASURE. >1 bit set -> multi_err=1, WAIT_LOW.
//  - MEASURE: b_q==latched bit -> len+1, saturating. b_q==0 -> judge, then IDLE.
//    Any other b_q -> multi_err=1, WAIT_LOW; no event is produced.
//  - WAIT_LOW: remain until b_q==0, then IDLE. No events or errors are issued while in WAIT_LOW.
//  Judge: len = number of cycles buzzer_in was high. In tolerance -> accept; otherwise len_err=1 for one cycle.
//  Accept: increments the zone counter. If evt_valid==0, or evt_ack==1 this cycle: evt_valid<=1 and
//    evt_zone<=zone. Otherwise the pending event is kept unchanged and overrun<=1.
//  Latency: buzzer_in first sampled low at edge k -> evt_valid/len_err high after edge k+1.
//  Handshake: evt_ack while evt_valid=1 clears evt_valid and evt_zone next edge, unless a new accept
//    occurs in the same cycle, in which case the new event replaces it. evt_ack while evt_valid=0 is ignored.
//  Counters: saturate at all-ones. clr_counts wins over a same-cycle increment.
//  Back-to-back pulses: a one-hot b_q in the cycle the previous pulse is judged is not captured.
//    At least one low cycle is required between pulses.
//  Reset mid-pulse: return to IDLE with len=0. A remainder of the pulse seen after reset release is measured
//    as a new pulse and is expected to fail tolerance (len_err).
// TESTING
//  1. zone2 high 31 cycles -> evt_valid, evt_zone=2 two edges after fall; zone2_cnt=1; ack clears next edge.
//  2. zone1 high 29 cycles, then 33 cycles -> len_err pulse each time, no evt_valid, counters unchanged.
//     Repeat with 30 and 32 cycles -> both accepted.
//  3. zone1 high 5 cycles, then zone3 added -> multi_err 1 cycle; nothing until lines low; next 31-cycle
//     pulse accepted.
//  4. two valid zone3 pulses with no ack -> evt_zone stays 3 from the first, overrun=1, zone3_cnt=2.
//     A third pulse with ack in its judge cycle -> new event shown, overrun stays 1.
//  5. 256 valid zone1 pulses -> zone1_cnt holds 255. clr_counts in a judge cycle -> count 0, evt_valid still set.
//  6. rst_n low at cycle 10 of a pulse -> all outputs 0 async; lines held high to cycle 31 then low ->
//     len_err, no event.

Source files
------------

// File: rtl/alarm_pulse_decoder_if.sv
// Alarm event handshake: decoder presents a zone code with valid; consumer acknowledges.
interface alarm_pulse_decoder_if;
  logic       evt_valid;
  logic [1:0] evt_zone;
  logic       evt_ack;

  modport master (
    output evt_valid,
    output evt_zone,
    input  evt_ack
  );

  modport slave (
    input  evt_valid,
    input  evt_zone,
    output evt_ack
  );
endinterface

// File: rtl/alarm_pulse_decoder.sv
// Checks buzzer pulses for single-zone, nominal-length shape and reports accepted alarms as
// zone events with saturating per-zone counts.
module alarm_pulse_decoder #(
  parameter int unsigned PULSE_LEN = 31,
  parameter int unsigned TOL       = 1,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             buzzer_in,
  input  logic                   clr_counts,
  alarm_pulse_decoder_if.master  evt_if,
  output logic                   len_err,
  output logic                   multi_err,
  output logic                   overrun,
  output logic [CNT_W-1:0]       zone1_cnt,
  output logic [CNT_W-1:0]       zone2_cnt,
  output logic [CNT_W-1:0]       zone3_cnt
);

  localparam int unsigned LenMin = PULSE_LEN - TOL;
  localparam int unsigned LenMax = PULSE_LEN + TOL;

  typedef enum logic [1:0] {StIdle, StMeasure, StWaitLow} state_e;

  state_e           state_q, state_d;
  logic [2:0]       b_q;
  logic [2:0]       zbit_q, zbit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             len_err_q, len_err_d;
  logic             multi_err_q, multi_err_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_zone_q, evt_zone_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic       accept;
  logic       in_tol;
  logic [1:0] zone_code;

  assign in_tol = (32'(len_q) >= LenMin) && (32'(len_q) <= LenMax);

  always_comb begin
    zone_code = 2'd0;
    unique case (zbit_q)
      3'b001:  zone_code = 2'd1;
      3'b010:  zone_code = 2'd2;
      3'b100:  zone_code = 2'd3;
      default: zone_code = 2'd0;
    endcase
  end

  // Pulse-shape FSM; operates on the registered buzzer lines.
  always_comb begin
    state_d     = state_q;
    zbit_d      = zbit_q;
    len_d       = len_q;
    len_err_d   = 1'b0;
    multi_err_d = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (b_q != 3'b000) begin
          if ($onehot(b_q)) begin
            zbit_d  = b_q;
            len_d   = LEN_W'(1);
            state_d = StMeasure;
          end else begin
            multi_err_d = 1'b1;
            state_d     = StWaitLow;
          end
        end
      end
      StMeasure: begin
        if (b_q == zbit_q) begin
          if (len_q != '1) len_d = len_q + LEN_W'(1);
        end else if (b_q == 3'b000) begin
          state_d = StIdle;
          len_d   = '0;
          if (in_tol) accept    = 1'b1;
          else        len_err_d = 1'b1;
        end else begin
          multi_err_d = 1'b1;
          len_d       = '0;
          state_d     = StWaitLow;
        end
      end
      StWaitLow: begin
        if (b_q == 3'b000) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A new accept overrides a same-cycle ack; an accept while still pending is lost.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_zone_d  = evt_zone_q;
    overrun_d   = overrun_q;
    if (accept) begin
      if (!evt_valid_q || evt_if.evt_ack) begin
        evt_valid_d = 1'b1;
        evt_zone_d  = zone_code;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (evt_if.evt_ack && evt_valid_q) begin
      evt_valid_d = 1'b0;
      evt_zone_d  = 2'd0;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_counts) begin
        cnt_d[i] = '0;
      end else if (accept && zbit_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      b_q         <= 3'b000;
      zbit_q      <= 3'b000;
      len_q       <= '0;
      len_err_q   <= 1'b0;
      multi_err_q <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_zone_q  <= 2'd0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= buzzer_in;
      zbit_q      <= zbit_d;
      len_q       <= len_d;
      len_err_q   <= len_err_d;
      multi_err_q <= multi_err_d;
      evt_valid_q <= evt_valid_d;
      evt_zone_q  <= evt_zone_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_zone  = evt_zone_q;
  assign len_err          = len_err_q;
  assign multi_err        = multi_err_q;
  assign overrun          = overrun_q;
  assign zone1_cnt        = cnt_q[0];
  assign zone2_cnt        = cnt_q[1];
  assign zone3_cnt        = cnt_q[2];

endmodule

// File: tb/tb_alarm_pulse_decoder.sv
// Directed bench for alarm_pulse_decoder: pulse length, multi-zone, overrun, saturation, reset.
module tb_alarm_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] buzzer_in;
  logic       clr_counts;
  logic       len_err, multi_err, overrun;
  logic [7:0] zone1_cnt, zone2_cnt, zone3_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic seen_len, seen_multi, seen_valid;

  alarm_pulse_decoder_if evt_if ();

  alarm_pulse_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buzzer_in  (buzzer_in),
    .clr_counts (clr_counts),
    .evt_if     (evt_if),
    .len_err    (len_err),
    .multi_err  (multi_err),
    .overrun    (overrun),
    .zone1_cnt  (zone1_cnt),
    .zone2_cnt  (zone2_cnt),
    .zone3_cnt  (zone3_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold the lines for n clock edges, sampling 1 time unit after each edge.
  task automatic drive(input logic [2:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      buzzer_in = bits;
      @(posedge clk);
      #1;
      seen_len   |= len_err;
      seen_multi |= multi_err;
      seen_valid |= evt_if.evt_valid;
    end
  endtask

  task automatic ack_evt();
    evt_if.evt_ack = 1'b1;
    @(posedge clk);
    #1;
    evt_if.evt_ack = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    buzzer_in      = 3'b000;
    clr_counts     = 1'b0;
    evt_if.evt_ack = 1'b0;
    seen_len       = 1'b0;
    seen_multi     = 1'b0;
    seen_valid     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(evt_if.evt_valid), 0);
    check("rst_zone", 32'(evt_if.evt_zone), 0);
    check("rst_len_err", 32'(len_err), 0);
    check("rst_multi_err", 32'(multi_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_z1", 32'(zone1_cnt), 0);
    rst_n = 1'b1;
    drive(3'b000, 2);

    // Nominal zone2 pulse, two-edge latency, ack clears
    drive(3'b010, 31);
    buzzer_in = 3'b000;
    @(posedge clk);
    #1;
    check("t1_latency", 32'(evt_if.evt_valid), 0);
    @(posedge clk);
    #1;
    check("t1_valid", 32'(evt_if.evt_valid), 1);
    check("t1_zone", 32'(evt_if.evt_zone), 2);
    check("t1_z2", 32'(zone2_cnt), 1);
    ack_evt();
    check("t1_ack_valid", 32'(evt_if.evt_valid), 0);
    check("t1_ack_zone", 32'(evt_if.evt_zone), 0);

    // Tolerance edges
    drive(3'b001, 29);
    drive(3'b000, 2);
    check("t2_29_len_err", 32'(len_err), 1);
    check("t2_29_valid", 32'(evt_if.evt_valid), 0);
    drive(3'b000, 1);
    check("t2_len_err_pulse", 32'(len_err), 0);
    drive(3'b001, 33);
    drive(3'b000, 2);
    check("t2_33_len_err", 32'(len_err), 1);
    check("t2_33_valid", 32'(evt_if.evt_valid), 0);
    check("t2_z1_unchanged", 32'(zone1_cnt), 0);
    drive(3'b001, 30);
    drive(3'b000, 2);
    check("t2_30_valid", 32'(evt_if.evt_valid), 1);
    check("t2_30_zone", 32'(evt_if.evt_zone), 1);
    check("t2_30_len_err", 32'(len_err), 0);
    check("t2_30_z1", 32'(zone1_cnt), 1);
    ack_evt();
    drive(3'b001, 32);
    drive(3'b000, 2);
    check("t2_32_valid", 32'(evt_if.evt_valid), 1);
    check("t2_32_z1", 32'(zone1_cnt), 2);
    ack_evt();

    // Multi-zone: error pulse, then ignored until lines go low
    drive(3'b001, 5);
    drive(3'b011, 2);
    check("t3_multi_err", 32'(multi_err), 1);
    check("t3_valid", 32'(evt_if.evt_valid), 0);
    seen_len   = 1'b0;
    seen_multi = 1'b0;
    seen_valid = 1'b0;
    drive(3'b011, 3);
    drive(3'b010, 31);
    drive(3'b000, 3);
    check("t3_wait_multi", 32'(seen_multi), 0);
    check("t3_wait_len", 32'(seen_len), 0);
    check("t3_wait_valid", 32'(seen_valid), 0);
    check("t3_z2_unchanged", 32'(zone2_cnt), 1);
    drive(3'b001, 31);
    drive(3'b000, 2);
    check("t3_recover_valid", 32'(evt_if.evt_valid), 1);
    check("t3_recover_zone", 32'(evt_if.evt_zone), 1);
    check("t3_recover_z1", 32'(zone1_cnt), 3);
    ack_evt();

    // Overrun: unacked events keep the first zone
    drive(3'b100, 31);
    drive(3'b000, 2);
    check("t4_first_zone", 32'(evt_if.evt_zone), 3);
    check("t4_first_overrun", 32'(overrun), 0);
    drive(3'b100, 31);
    drive(3'b000, 2);
    check("t4_second_zone", 32'(evt_if.evt_zone), 3);
    check("t4_second_overrun", 32'(overrun), 1);
    check("t4_z3", 32'(zone3_cnt), 2);
    drive(3'b001, 31);
    drive(3'b000, 2);
    check("t4_kept_zone", 32'(evt_if.evt_zone), 3);
    check("t4_z1", 32'(zone1_cnt), 4);
    drive(3'b010, 31);
    buzzer_in = 3'b000;
    @(posedge clk);
    #1;
    evt_if.evt_ack = 1'b1;
    @(posedge clk);
    #1;
    evt_if.evt_ack = 1'b0;
    check("t4_replace_valid", 32'(evt_if.evt_valid), 1);
    check("t4_replace_zone", 32'(evt_if.evt_zone), 2);
    check("t4_overrun_sticky", 32'(overrun), 1);
    check("t4_z2", 32'(zone2_cnt), 2);
    ack_evt();
    check("t4_acked", 32'(evt_if.evt_valid), 0);

    // Counter clear and saturation
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    check("t5_clr_z1", 32'(zone1_cnt), 0);
    check("t5_clr_z2", 32'(zone2_cnt), 0);
    check("t5_clr_z3", 32'(zone3_cnt), 0);
    for (int i = 0; i < 256; i++) begin
      drive(3'b001, 31);
      drive(3'b000, 2);
    end
    check("t5_sat_z1", 32'(zone1_cnt), 255);
    ack_evt();
    check("t5_acked", 32'(evt_if.evt_valid), 0);
    drive(3'b001, 31);
    buzzer_in = 3'b000;
    @(posedge clk);
    #1;
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    check("t5_clr_wins", 32'(zone1_cnt), 0);
    check("t5_clr_valid", 32'(evt_if.evt_valid), 1);
    check("t5_clr_zone", 32'(evt_if.evt_zone), 1);

    // Asynchronous reset mid-pulse; the remainder fails tolerance
    drive(3'b010, 10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(evt_if.evt_valid), 0);
    check("t6_rst_zone", 32'(evt_if.evt_zone), 0);
    check("t6_rst_overrun", 32'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(3'b010, 20);
    seen_valid = 1'b0;
    drive(3'b000, 2);
    check("t6_len_err", 32'(len_err), 1);
    check("t6_no_valid", 32'(seen_valid), 0);
    check("t6_z2", 32'(zone2_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
